// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the multi-digit LCD driver.
package lcd_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ERROR = 8'h3A;
    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/lcd_char_decode.sv
// BCD digit to ASCII: 0-9 map to '0'-'9', anything above 9 shows ':' as an error marker.
module lcd_char_decode
    import lcd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_ERROR;
        if (bcd <= 4'd9) begin
            ascii = ASCII_ZERO + {4'd0, bcd};
        end
    end

endmodule

// File: rtl/lcd_multi_driver.sv
// Frame-snapshotting multi-digit LCD character streamer with latched alarm detection.
// Optional blinking of key-entry frames is enabled by defining LCD_BLINK_EN.
module lcd_multi_driver
    import lcd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ALARM_CYCLES = 1000,
    parameter int BLINK_CYCLES = 500,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int TW = 4 * NUM_DIGITS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [TW-1:0] key_buffer,
    input  logic [TW-1:0] alarm_time,
    input  logic [TW-1:0] current_time,
    input  logic          show_new_time,
    input  logic          show_alarm,
    input  logic          alarm_enable,
    input  logic          alarm_ack,
    input  logic          lcd_ready,
    output logic [7:0]    lcd_char,
    output logic          lcd_valid,
    output logic [DW-1:0] lcd_digit,
    output logic          lcd_frame_end,
    output logic          sound_alarm,
    output logic [1:0]    fsm_state
);

    localparam int CW = $clog2(ALARM_CYCLES + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] src, snap_q;
    logic [DW-1:0] idx_q;
    logic [3:0]    digit_sel;
    logic [7:0]    dec_char;
    logic          blank;
    logic          handshake;
    logic          match, match_q, trigger;
    logic [CW-1:0] alarm_cnt;

    // Handshake: a character transfers on a cycle where lcd_valid && lcd_ready;
    // while valid is high and ready is low, char/digit/frame_end hold and valid stays high.
    assign handshake = lcd_valid && lcd_ready;

    always_comb begin
        src = current_time;
        if (show_new_time) begin
            src = key_buffer;
        end else if (show_alarm) begin
            src = alarm_time;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (handshake && idx_q == '0) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot is the only copy of the frame; sources may change freely mid-frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
            idx_q  <= '0;
        end else if (state_q == LOAD) begin
            snap_q <= src;
            idx_q  <= DW'(NUM_DIGITS - 1);
        end else if (handshake && idx_q != '0) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == DW'(i)) begin
                digit_sel = snap_q[4*i +: 4];
            end
        end
    end

    lcd_char_decode u_decode (
        .bcd   (digit_sel),
        .ascii (dec_char)
    );

`ifdef LCD_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          blank_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (state_q == LOAD) begin
                blank_q <= show_new_time && phase;
            end
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign lcd_valid     = (state_q == SEND);
    assign lcd_char      = !lcd_valid ? 8'h00 : (blank ? ASCII_BLANK : dec_char);
    assign lcd_digit     = lcd_valid ? idx_q : '0;
    assign lcd_frame_end = lcd_valid && (idx_q == '0);
    assign fsm_state     = state_q;

    // Rising edge of match only; a persisting or repeated match while sounding is ignored.
    assign match   = (alarm_time == current_time);
    assign trigger = match && !match_q && alarm_enable && !sound_alarm;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_q     <= 1'b0;
            sound_alarm <= 1'b0;
            alarm_cnt   <= '0;
        end else begin
            match_q <= match;
            if (sound_alarm) begin
                if (alarm_ack || !alarm_enable || alarm_cnt == CW'(1)) begin
                    sound_alarm <= 1'b0;
                    alarm_cnt   <= '0;
                end else begin
                    alarm_cnt <= alarm_cnt - 1'b1;
                end
            end else if (trigger && !alarm_ack) begin
                sound_alarm <= 1'b1;
                alarm_cnt   <= CW'(ALARM_CYCLES);
            end
        end
    end

endmodule
